carfield_jtag_idcode_reader: RTL and testbench



---
 rtl/carfield_jtag_idcode_reader.sv | 157 +++++++++++++++
 tb/tb_carfield_jtag_idcode_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_jtag_idcode_reader.sv
// JTAG initiator: resets an external TAP, walks it to Shift-DR and reads the 32-bit IDCODE.
// Ports: clk_i/rst_ni (async active-low); start_i (accepted while busy_o=0);
//   busy_o, done_o (1-cycle pulse), idcode_o/match_o/valid_o (updated with done_o);
//   jtag_tck_o/jtag_tms_o/jtag_tdi_o/jtag_trst_no outputs, jtag_tdo_i input.
// Option: define CARFIELD_JTAG_TRST_EN to pull jtag_trst_no low during the TLR periods.
module carfield_jtag_idcode_reader #(
    parameter logic [31:0] ExpIdCode = 32'h1ABC0DB3,
    parameter int unsigned ClkDiv    = 4,
    parameter int unsigned ResetTcks = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] idcode_o,
    output logic        match_o,
    output logic        valid_o,
    output logic        jtag_tck_o,
    output logic        jtag_tms_o,
    output logic        jtag_tdi_o,
    input  logic        jtag_tdo_i,
    output logic        jtag_trst_no
);

    typedef enum logic [3:0] {
        IDLE, TLR, RTI, SEL_DR, CAP_DR, SHIFT, EXIT1, UPDATE, FINISH
    } state_t;

    localparam int unsigned DW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int unsigned RW = $clog2(ResetTcks);
    localparam logic [DW-1:0] DivLast = DW'(ClkDiv - 1);
    localparam logic [RW-1:0] TlrLast = RW'(ResetTcks - 1);

`ifdef CARFIELD_JTAG_TRST_EN
    localparam logic TrstTlr = 1'b0;
`else
    localparam logic TrstTlr = 1'b1;
`endif

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [RW-1:0] rep_cnt;
    logic [4:0]    bit_cnt;
    logic [31:0]   shreg;
    logic          div_last;
    logic          accept;

    assign jtag_tdi_o = 1'b1;
    assign div_last   = (div_cnt == DivLast);
    // FINISH already has busy_o low, so a start there is taken as well.
    assign accept     = start_i && (state == IDLE || state == FINISH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            div_cnt      <= '0;
            rep_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            idcode_o     <= '0;
            match_o      <= 1'b0;
            valid_o      <= 1'b0;
            jtag_tck_o   <= 1'b0;
            jtag_tms_o   <= 1'b1;
            jtag_trst_no <= 1'b1;
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                state        <= TLR;
                div_cnt      <= '0;
                rep_cnt      <= '0;
                bit_cnt      <= '0;
                busy_o       <= 1'b1;
                jtag_tck_o   <= 1'b0;
                jtag_tms_o   <= 1'b1;
                jtag_trst_no <= TrstTlr;
            end else begin
                unique case (state)
                    IDLE: ;
                    FINISH: state <= IDLE;
                    default: begin
                        if (!div_last) begin
                            div_cnt <= div_cnt + 1'b1;
                        end else begin
                            div_cnt    <= '0;
                            jtag_tck_o <= ~jtag_tck_o;
                            if (!jtag_tck_o) begin
                                // TCK rising: the TAP is in Shift-DR here.
                                if (state == SHIFT) begin
                                    shreg <= {jtag_tdo_i, shreg[31:1]};
                                end
                            end else begin
                                // TCK falling: end of period, set up the next TMS.
                                unique case (state)
                                    TLR: begin
                                        if (rep_cnt == TlrLast) begin
                                            state        <= RTI;
                                            rep_cnt      <= '0;
                                            jtag_tms_o   <= 1'b0;
                                            jtag_trst_no <= 1'b1;
                                        end else begin
                                            rep_cnt <= rep_cnt + 1'b1;
                                        end
                                    end
                                    RTI: begin
                                        state      <= SEL_DR;
                                        jtag_tms_o <= 1'b1;
                                    end
                                    SEL_DR: begin
                                        state      <= CAP_DR;
                                        jtag_tms_o <= 1'b0;
                                    end
                                    // Two TMS=0 periods: one enters Capture-DR,
                                    // the next captures and enters Shift-DR.
                                    CAP_DR: begin
                                        if (rep_cnt == RW'(1)) begin
                                            state   <= SHIFT;
                                            rep_cnt <= '0;
                                        end else begin
                                            rep_cnt <= rep_cnt + 1'b1;
                                        end
                                    end
                                    SHIFT: begin
                                        if (bit_cnt == 5'd31) begin
                                            state      <= EXIT1;
                                            jtag_tms_o <= 1'b1;
                                        end else begin
                                            bit_cnt    <= bit_cnt + 1'b1;
                                            jtag_tms_o <= (bit_cnt == 5'd30);
                                        end
                                    end
                                    EXIT1: begin
                                        state      <= UPDATE;
                                        jtag_tms_o <= 1'b0;
                                    end
                                    UPDATE: begin
                                        state    <= FINISH;
                                        busy_o   <= 1'b0;
                                        done_o   <= 1'b1;
                                        idcode_o <= shreg;
                                        match_o  <= (shreg == ExpIdCode);
                                        valid_o  <= shreg[0];
                                    end
                                    default: state <= IDLE;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_carfield_jtag_idcode_reader.sv
// Bench for carfield_jtag_idcode_reader: IEEE TAP model, per-cycle reference model
// and directed reads at ClkDiv=4 and ClkDiv=1.
module tb_carfield_jtag_idcode_reader;

    localparam logic [31:0] EXP = 32'h1ABC0DB3;
    localparam int R = 5;

    localparam int TLR_S = 0, RTI_S = 1, SELDR = 2, CAPDR = 3, SHDR = 4;
    localparam int E1DR = 5, PDR = 6, E2DR = 7, UPDR = 8, SELIR = 9;
    localparam int CAPIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UPIR = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1;
    logic busy0, done0, match0, valid0, tck0, tms0, tdi0, trst0;
    logic busy1, done1, match1, valid1, tck1, tms1, tdi1, trst1;
    logic [31:0] id0, id1;
    logic tdo0 = 1'b0;
    logic tdo1;
    assign tdo1 = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    carfield_jtag_idcode_reader u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0),
        .busy_o(busy0), .done_o(done0), .idcode_o(id0),
        .match_o(match0), .valid_o(valid0),
        .jtag_tck_o(tck0), .jtag_tms_o(tms0), .jtag_tdi_o(tdi0),
        .jtag_tdo_i(tdo0), .jtag_trst_no(trst0)
    );

    carfield_jtag_idcode_reader #(.ClkDiv(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1),
        .busy_o(busy1), .done_o(done1), .idcode_o(id1),
        .match_o(match1), .valid_o(valid1),
        .jtag_tck_o(tck1), .jtag_tms_o(tms1), .jtag_tdi_o(tdi1),
        .jtag_tdo_i(tdo1), .jtag_trst_no(trst1)
    );

    // ---------------- TAP model for instance 0 ----------------
    logic [31:0] tap_id0;
    logic [31:0] dr0;
    int ts0 = PIR;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR_S: return m ? TLR_S : RTI_S;
            RTI_S: return m ? SELDR : RTI_S;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? E1DR : SHDR;
            SHDR:  return m ? E1DR : SHDR;
            E1DR:  return m ? UPDR : PDR;
            PDR:   return m ? E2DR : PDR;
            E2DR:  return m ? UPDR : SHDR;
            UPDR:  return m ? SELDR : RTI_S;
            SELIR: return m ? TLR_S : CAPIR;
            CAPIR: return m ? E1IR : SHIR;
            SHIR:  return m ? E1IR : SHIR;
            E1IR:  return m ? UPIR : PIR;
            PIR:   return m ? E2IR : PIR;
            E2IR:  return m ? UPIR : SHIR;
            default: return m ? SELDR : RTI_S;
        endcase
    endfunction

    always @(posedge tck0 or negedge trst0) begin
        if (!trst0) begin
            ts0 = TLR_S;
        end else begin
            if (ts0 == SHDR) dr0 = {tdi0, dr0[31:1]};
            else if (ts0 == CAPDR) dr0 = tap_id0;
            ts0 = tap_next(ts0, tms0);
        end
    end

    always @(negedge tck0) tdo0 = (ts0 == SHDR) ? dr0[0] : 1'b0;

    // ---------------- reference model ----------------
    bit          m_run [2];
    int          m_t   [2];
    logic [31:0] m_id  [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // 43 TCK periods plus the cycle that follows the accepting edge.
    function automatic int lat_of(input int i);
        return 1 + (R + 38) * 2 * div_of(i);
    endfunction

    // TMS per period index: R resets, RTI, SEL, CAP, enter-shift,
    // 32 shift periods (last with TMS=1), EXIT1, UPDATE.
    function automatic logic tms_exp(input int p);
        int q;
        if (p < R) return 1'b1;
        q = p - R;
        if (q == 1 || q == 35 || q == 36) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic start_of(input int i);
        return (i == 0) ? start0 : start1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 1'b0;
                m_t[i]   = 0;
                m_id[i]  = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit fin;
                fin = m_run[i] && (m_t[i] == lat_of(i) - 1);
                if (m_run[i]) m_t[i]++;
                if (fin) m_run[i] = 1'b0;
                if ((!m_run[i] || fin) && start_of(i)) begin
                    m_run[i] = 1'b1;
                    m_t[i]   = 0;
                end
                if (m_run[i] && m_t[i] == lat_of(i) - 1)
                    m_id[i] = (i == 0) ? tap_id0 : 32'hFFFFFFFF;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int i, input logic b, input logic dn, input logic tk,
                       input logic tm, input logic tr, input logic ti,
                       input logic [31:0] id, input logic mt, input logic vl);
        int d, l, p;
        logic be, de, tre;
        d  = div_of(i);
        l  = lat_of(i);
        be = m_run[i] && (m_t[i] < l - 1);
        de = m_run[i] && (m_t[i] == l - 1);
        p  = m_t[i] / (2 * d);
`ifdef CARFIELD_JTAG_TRST_EN
        tre = !(be && p < R);
`else
        tre = 1'b1;
`endif
        chk($sformatf("busy%0d", i), 32'(b), 32'(be));
        chk($sformatf("done%0d", i), 32'(dn), 32'(de));
        chk($sformatf("tck%0d", i), 32'(tk), 32'(be && ((m_t[i] % (2 * d)) >= d)));
        if (be) chk($sformatf("tms%0d_p%0d", i, p), 32'(tm), 32'(tms_exp(p)));
        chk($sformatf("trst%0d", i), 32'(tr), 32'(tre));
        chk($sformatf("tdi%0d", i), 32'(ti), 32'd1);
        chk($sformatf("idcode%0d", i), id, m_id[i]);
        chk($sformatf("match%0d", i), 32'(mt), 32'(m_id[i] == EXP));
        chk($sformatf("valid%0d", i), 32'(vl), 32'(m_id[i][0]));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            cmp(0, busy0, done0, tck0, tms0, trst0, tdi0, id0, match0, valid0);
            cmp(1, busy1, done1, tck1, tms1, trst1, tdi1, id1, match1, valid1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_start(input int i, input logic v);
        if (i == 0) start0 = v;
        else start1 = v;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_tck"}, 32'(tck0), 32'd0);
        chk({tag, "_tms"}, 32'(tms0), 32'd1);
        chk({tag, "_tdi"}, 32'(tdi0), 32'd1);
        chk({tag, "_trst"}, 32'(trst0), 32'd1);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_id"}, id0, 32'd0);
        chk({tag, "_match"}, 32'(match0), 32'd0);
        chk({tag, "_valid"}, 32'(valid0), 32'd0);
    endtask

    task automatic run_read(input int i, input int exp_lat, input logic [31:0] exp_id,
                            input logic exp_m, input logic exp_v,
                            input bit extra, input int abort_at);
        int nd, lat;
        nd  = 0;
        lat = -1;
        @(negedge clk);
        set_start(i, 1'b1);
        @(posedge clk);
        #1 set_start(i, 1'b0);
        for (int n = 1; n <= exp_lat + 20; n++) begin
            @(negedge clk);
            if (extra && (n == 10 || n == 200)) set_start(i, 1'b1);
            if (extra && (n == 11 || n == 201)) set_start(i, 1'b0);
            if (n == abort_at) begin
                #2 rst_n = 1'b0;
                #1 reset_vals("midreset");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if ((i == 0) ? done0 : done1) begin
                nd++;
                if (lat < 0) lat = n;
            end
        end
        chk($sformatf("latency%0d", i), 32'(lat), 32'(exp_lat));
        chk($sformatf("done_count%0d", i), 32'(nd), 32'd1);
        chk($sformatf("id_lit%0d", i), (i == 0) ? id0 : id1, exp_id);
        chk($sformatf("match_lit%0d", i), 32'((i == 0) ? match0 : match1), 32'(exp_m));
        chk($sformatf("valid_lit%0d", i), 32'((i == 0) ? valid0 : valid1), 32'(exp_v));
    endtask

    initial begin
        rst_n   = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        tap_id0 = 32'h1ABC0DB3;
        repeat (3) @(negedge clk);
        reset_vals("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_read(0, 345, 32'h1ABC0DB3, 1'b1, 1'b1, 1'b0, 0);
        chk("tap_end_rti", 32'(ts0), 32'(RTI_S));

        tap_id0 = 32'h1ABC0DB2;
        run_read(0, 345, 32'h1ABC0DB2, 1'b0, 1'b0, 1'b0, 0);

        run_read(1, 87, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 0);

        tap_id0 = 32'h1ABC0DB3;
        run_read(0, 345, 32'h1ABC0DB3, 1'b1, 1'b1, 1'b1, 0);

        // reset lands in shift period for bit 12
        run_read(0, 345, 32'h1ABC0DB3, 1'b1, 1'b1, 1'b0, 170);
        repeat (2) @(negedge clk);
        run_read(0, 345, 32'h1ABC0DB3, 1'b1, 1'b1, 1'b0, 0);
        chk("tap_end_rti2", 32'(ts0), 32'(RTI_S));

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
